// File: rtl/gain_coeff_if.sv
// Bundle between the scaled-stream / gain stage and the coefficient
// controller: sync strobe, per-frame peaks, manual/auto coefficients.
interface gain_coeff_if #(
  parameter int BITWIDTH = 7
);
  logic                en_sync_in;
  logic [BITWIDTH+1:0] cnt_sync_in;
  logic [31:0]         max_I;
  logic [31:0]         max_Q;
  logic [31:0]         max_U;
  logic [31:0]         max_V;
  logic                auto_en;
  logic [15:0]         manual_coeff_I;
  logic [15:0]         manual_coeff_Q;
  logic [15:0]         manual_coeff_U;
  logic [15:0]         manual_coeff_V;
  logic [15:0]         scaled_coeff_I;
  logic [15:0]         scaled_coeff_Q;
  logic [15:0]         scaled_coeff_U;
  logic [15:0]         scaled_coeff_V;
  logic                coeff_update;
  logic                busy;
  logic                overrun;

  modport master (
    output en_sync_in,
    output cnt_sync_in,
    output max_I,
    output max_Q,
    output max_U,
    output max_V,
    output auto_en,
    output manual_coeff_I,
    output manual_coeff_Q,
    output manual_coeff_U,
    output manual_coeff_V,
    input  scaled_coeff_I,
    input  scaled_coeff_Q,
    input  scaled_coeff_U,
    input  scaled_coeff_V,
    input  coeff_update,
    input  busy,
    input  overrun
  );

  modport slave (
    input  en_sync_in,
    input  cnt_sync_in,
    input  max_I,
    input  max_Q,
    input  max_U,
    input  max_V,
    input  auto_en,
    input  manual_coeff_I,
    input  manual_coeff_Q,
    input  manual_coeff_U,
    input  manual_coeff_V,
    output scaled_coeff_I,
    output scaled_coeff_Q,
    output scaled_coeff_U,
    output scaled_coeff_V,
    output coeff_update,
    output busy,
    output overrun
  );
endinterface

// File: rtl/gain_coeff_ctrl.sv
// Per-frame automatic gain coefficient controller: latches channel
// peaks, divides a target by each peak serially, commits all four.
module gain_coeff_ctrl #(
  parameter int          BITWIDTH   = 7,
  parameter int          LAST_CNT   = 511,
  parameter int          MAX_LAT    = 2,
  parameter logic [15:0] TARGET     = 16'h4000,
  parameter int          COEFF_FRAC = 12
) (
  input logic       clk,
  input logic       rst,
  gain_coeff_if.slave bus
);

  localparam int          CNT_W    = BITWIDTH + 2;
  localparam logic [31:0] DIVIDEND = 32'(TARGET) << COEFF_FRAC;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DIV,
    COMMIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              frame_end;
  logic [3:0]        lat_cnt;
  logic [5:0]        phase;
  logic [1:0]        ch;
  logic [3:0][31:0]  max_r;
  logic [31:0]       rem;
  logic [31:0]       quo;
  logic [31:0]       dvs;
  logic [3:0][15:0]  stage;
  logic [3:0][15:0]  result;
  logic              ovr;

  logic              load_lat;
  logic              lat_dec;
  logic              latch_max;
  logic              div_load;
  logic              div_step;
  logic              div_done;
  logic              commit;
  logic              busy;

  logic [32:0]       shifted;
  logic [32:0]       trial;
  logic [31:0]       rem_nxt;
  logic [31:0]       quo_nxt;
  logic [15:0]       q_sat;

  assign frame_end = bus.en_sync_in &&
                     (bus.cnt_sync_in == CNT_W'(LAST_CNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (frame_end) state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_cnt == 4'd0) state_nxt = DIV;
      end
      DIV: begin
        if (phase == 6'd32 && ch == 2'd3) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load_lat  = 1'b0;
    lat_dec   = 1'b0;
    latch_max = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    div_done  = 1'b0;
    commit    = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy     = 1'b0;
        load_lat = frame_end;
      end
      WAIT: begin
        latch_max = (lat_cnt == 4'd0);
        lat_dec   = (lat_cnt != 4'd0);
      end
      DIV: begin
        div_load = (phase == 6'd0);
        div_step = (phase != 6'd0);
        div_done = (phase == 6'd32);
      end
      COMMIT: begin
        commit = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // One restoring step: shift in the next dividend bit, keep the
  // trial remainder only when it does not go negative.
  always_comb begin
    shifted = {rem, quo[31]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[32]) begin
      rem_nxt = trial[31:0];
      quo_nxt = {quo[30:0], 1'b1};
    end else begin
      rem_nxt = shifted[31:0];
      quo_nxt = {quo[30:0], 1'b0};
    end
    if (dvs == 32'd0 || quo_nxt[31:16] != 16'd0) begin
      q_sat = 16'hFFFF;
    end else begin
      q_sat = quo_nxt[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_cnt <= '0;
    end else if (load_lat) begin
      lat_cnt <= 4'(MAX_LAT - 1);
    end else if (lat_dec) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_r <= '0;
      phase <= '0;
      ch    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      stage <= {4{16'hFFFF}};
    end else begin
      if (latch_max) begin
        max_r <= {bus.max_V, bus.max_U, bus.max_Q, bus.max_I};
        ch    <= 2'd0;
        phase <= 6'd0;
      end
      if (div_load) begin
        rem   <= 32'd0;
        quo   <= DIVIDEND;
        dvs   <= max_r[ch];
        phase <= 6'd1;
      end
      if (div_step) begin
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (div_done) begin
          stage[ch] <= q_sat;
          ch        <= ch + 2'd1;
          phase     <= 6'd0;
        end else begin
          phase <= phase + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result <= {4{16'hFFFF}};
    end else if (commit) begin
      result <= stage;
    end
  end

  // Sticky: any frame end we had to drop since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr <= 1'b0;
    end else if (frame_end && busy) begin
      ovr <= 1'b1;
    end
  end

  assign bus.scaled_coeff_I = bus.auto_en ? result[0] : bus.manual_coeff_I;
  assign bus.scaled_coeff_Q = bus.auto_en ? result[1] : bus.manual_coeff_Q;
  assign bus.scaled_coeff_U = bus.auto_en ? result[2] : bus.manual_coeff_U;
  assign bus.scaled_coeff_V = bus.auto_en ? result[3] : bus.manual_coeff_V;
  assign bus.coeff_update   = commit;
  assign bus.busy           = busy;
  assign bus.overrun        = ovr;

endmodule

// File: tb/tb_gain_coeff_ctrl.sv
// Bench for gain_coeff_ctrl: vector table, corner sequences and
// random peaks checked against an arithmetic reference.
module tb_gain_coeff_ctrl;

  localparam int BITWIDTH   = 7;
  localparam int LAST_CNT   = 511;
  localparam int MAX_LAT    = 2;
  localparam int COEFF_FRAC = 12;
  localparam logic [15:0] TARGET = 16'h4000;
  localparam int COMMIT_AT  = MAX_LAT + 132;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  gain_coeff_if #(.BITWIDTH(BITWIDTH)) bus ();

  gain_coeff_ctrl #(
    .BITWIDTH  (BITWIDTH),
    .LAST_CNT  (LAST_CNT),
    .MAX_LAT   (MAX_LAT),
    .TARGET    (TARGET),
    .COEFF_FRAC(COEFF_FRAC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][31:0] mx;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vt[4];

  function automatic logic [15:0] model_coeff(input logic [31:0] m);
    longint unsigned num;
    longint unsigned q;
    num = longint'(TARGET) << COEFF_FRAC;
    if (m == 32'd0) return 16'hFFFF;
    q = num / longint'({32'd0, m});
    if (q > 64'd65535) return 16'hFFFF;
    return 16'(q);
  endfunction

  function automatic logic [3:0][15:0] model_set(input logic [3:0][31:0] m);
    logic [3:0][15:0] r;
    for (int i = 0; i < 4; i++) r[i] = model_coeff(m[i]);
    return r;
  endfunction

  function automatic logic [3:0][15:0] cur_outs();
    return {bus.scaled_coeff_V, bus.scaled_coeff_U,
            bus.scaled_coeff_Q, bus.scaled_coeff_I};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [3:0][15:0] exp);
    logic [3:0][15:0] o;
    o = cur_outs();
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_coeff%0d", name, i), 32'(o[i]), 32'(exp[i]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_max(input logic [3:0][31:0] m);
    bus.max_I = m[0];
    bus.max_Q = m[1];
    bus.max_U = m[2];
    bus.max_V = m[3];
  endtask

  task automatic fire();
    bus.en_sync_in  = 1'b1;
    bus.cnt_sync_in = 9'(LAST_CNT);
    tick();
    bus.en_sync_in  = 1'b0;
    bus.cnt_sync_in = 9'($urandom_range(0, LAST_CNT - 1));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic watch(input int n, output int pulses, output int first);
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.coeff_update) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic run_frame(input logic [3:0][15:0] exp, input bit swap,
                           input logic [3:0][31:0] alt, input string tag);
    int pulses;
    int at;
    bit stable;
    logic [3:0][15:0] prev;
    prev   = cur_outs();
    pulses = 0;
    at     = -1;
    stable = 1'b1;
    fire();
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= COMMIT_AT + 8; k++) begin
      tick();
      if (swap && k == MAX_LAT) set_max(alt);
      if (bus.coeff_update) begin
        pulses++;
        if (at < 0) at = k;
      end
      if (k <= COMMIT_AT && cur_outs() !== prev) stable = 1'b0;
    end
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    chk({tag, "_pulse_cycle"}, 32'(at), 32'(COMMIT_AT));
    chk({tag, "_hold_until_commit"}, 32'(stable), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk_outs(tag, exp);
  endtask

  initial begin
    logic [3:0][31:0] ma;
    logic [3:0][31:0] mb;
    logic [3:0][15:0] man;
    int p1;
    int f1;
    int p2;
    int f2;

    n_cmp = 0;
    n_bad = 0;

    vt[0].mx  = {32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000};
    vt[0].exp = {16'h0400, 16'h0400, 16'h0400, 16'h0400};
    vt[1].mx  = {32'h0004_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vt[1].exp = {16'h0100, 16'h0000, 16'hFFFF, 16'hFFFF};
    vt[2].mx  = {32'h0000_0400, 32'h0800_0000, 32'h0200_0000, 32'h0400_0000};
    vt[2].exp = {16'hFFFF, 16'h0000, 16'h0002, 16'h0001};
    vt[3].mx  = {32'h0300_0000, 32'h0400_0001, 32'h0000_0003, 32'h0000_0401};
    vt[3].exp = {16'h0001, 16'h0000, 16'hFFFF, 16'hFFC0};

    rst = 1'b0;
    bus.en_sync_in = 1'b0;
    bus.cnt_sync_in = '0;
    bus.auto_en = 1'b1;
    bus.manual_coeff_I = 16'h0;
    bus.manual_coeff_Q = 16'h0;
    bus.manual_coeff_U = 16'h0;
    bus.manual_coeff_V = 16'h0;
    set_max('0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    chk_outs("reset", {4{16'hFFFF}});
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_overrun", 32'(bus.overrun), 32'd0);
    chk("reset_update", 32'(bus.coeff_update), 32'd0);

    for (int i = 0; i < 4; i++) begin
      set_max(vt[i].mx);
      run_frame(vt[i].exp, 1'b0, '0, $sformatf("vec%0d", i));
    end

    bus.auto_en = 1'b0;
    bus.manual_coeff_I = 16'h1234;
    bus.manual_coeff_Q = 16'h1234;
    bus.manual_coeff_U = 16'h1234;
    bus.manual_coeff_V = 16'h1234;
    #1;
    chk_outs("manual", {4{16'h1234}});
    bus.auto_en = 1'b1;
    #1;
    chk_outs("auto_back", vt[3].exp);

    // Reset in the middle of the divide.
    ma = {32'h0000_2000, 32'h0000_1000, 32'h0000_0800, 32'h0000_0400};
    set_max(ma);
    fire();
    watch(MAX_LAT + 60, p1, f1);
    chk("middiv_no_update", 32'(p1), 32'd0);
    rst = 1'b0;
    #1;
    chk_outs("middiv_rst", {4{16'hFFFF}});
    chk("middiv_rst_busy", 32'(bus.busy), 32'd0);
    chk("middiv_rst_update", 32'(bus.coeff_update), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mb = {32'h0000_8000, 32'h0002_0000, 32'h0000_0100, 32'h0010_0000};
    set_max(mb);
    run_frame(model_set(mb), 1'b0, '0, "after_rst");

    // Peaks change right after the latch point.
    ma = {32'h0000_3000, 32'h0001_5000, 32'h0007_0000, 32'h0000_9000};
    mb = {32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 32'h0000_0007};
    set_max(ma);
    run_frame(model_set(ma), 1'b1, mb, "late_change");

    // Second frame end while busy.
    do_reset();
    ma = {32'h0000_1100, 32'h0002_2000, 32'h0003_3000, 32'h0004_4000};
    set_max(ma);
    fire();
    watch(50, p1, f1);
    chk("busyfe_overrun_before", 32'(bus.overrun), 32'd0);
    set_max({4{32'h0000_0010}});
    fire();
    chk("busyfe_overrun_after", 32'(bus.overrun), 32'd1);
    watch(150, p2, f2);
    chk("busyfe_pulses", 32'(p1 + p2), 32'd1);
    chk("busyfe_pulse_cycle", 32'(f2), 32'(COMMIT_AT - 51));
    chk_outs("busyfe", model_set(ma));

    // Frame end landing on the commit cycle.
    do_reset();
    ma = {32'h0000_7000, 32'h0000_6000, 32'h0000_5000, 32'h0000_4000};
    set_max(ma);
    fire();
    watch(COMMIT_AT, p1, f1);
    chk("commitfe_seen", 32'(bus.coeff_update), 32'd1);
    fire();
    chk("commitfe_overrun", 32'(bus.overrun), 32'd1);
    chk("commitfe_busy", 32'(bus.busy), 32'd0);
    chk_outs("commitfe", model_set(ma));
    watch(150, p2, f2);
    chk("commitfe_no_second", 32'(p2), 32'd0);

    // Frame end one cycle after commit is taken.
    do_reset();
    set_max(ma);
    fire();
    watch(COMMIT_AT + 1, p1, f1);
    mb = {32'h0000_0900, 32'h0000_0A00, 32'h0000_0B00, 32'h0000_0C00};
    set_max(mb);
    fire();
    chk("postcommit_busy", 32'(bus.busy), 32'd1);
    chk("postcommit_overrun", 32'(bus.overrun), 32'd0);
    watch(COMMIT_AT + 4, p2, f2);
    chk("postcommit_pulses", 32'(p2), 32'd1);
    chk("postcommit_cycle", 32'(f2), 32'(COMMIT_AT));
    chk_outs("postcommit", model_set(mb));

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 4; c++) begin
        ma[c] = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) ma[c] = 32'd0;
      end
      set_max(ma);
      run_frame(model_set(ma), 1'b0, '0, $sformatf("rand%0d", r));
      for (int c = 0; c < 4; c++) man[c] = 16'($urandom);
      bus.manual_coeff_I = man[0];
      bus.manual_coeff_Q = man[1];
      bus.manual_coeff_U = man[2];
      bus.manual_coeff_V = man[3];
      bus.auto_en = 1'b0;
      #1;
      chk_outs($sformatf("rand%0d_man", r), man);
      bus.auto_en = 1'b1;
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
